pattern_detect_fsm_param: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the fixed 2-bit-state "101" Moore detector.
- Pattern value and length are programmable at run time, up to PAT_W bits.
- Supports overlapping and non-overlapping match modes, input qualification and a saturating match counter.
- Sits on a serial data path after the bit synchroniser; drives a registered one-cycle detect pulse to downstream control logic.

---
 rtl/pattern_detect_fsm_param_if.sv | 29 ++
 rtl/pattern_detect_fsm_param.sv | 109 ++++++++++
 tb/tb_pattern_detect_fsm_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_detect_fsm_param_if.sv
// Handshake/config/status bundle for the programmable serial pattern detector.
interface pattern_detect_fsm_param_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             clr_count;
  logic             pattern_detect;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             cfg_err;
  logic             busy;

  modport master (
    output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    input  pattern_detect, match_count, count_sat, cfg_err, busy
  );

  modport slave (
    input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    output pattern_detect, match_count, count_sat, cfg_err, busy
  );
endinterface

// File: rtl/pattern_detect_fsm_param.sv
// Run-time programmable serial bit-pattern detector with overlap/non-overlap modes,
// qualified input and a saturating match counter.
module pattern_detect_fsm_param #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  pattern_detect_fsm_param_if.slave   bus
);

  typedef enum logic [1:0] {UNCFG = 2'd0, FILL = 2'd1, HUNT = 2'd2} state_t;

  state_t           state, state_d;
  logic [PAT_W-1:0] hist, hist_shift, hist_d;
  logic [PAT_W-1:0] pat, mask;
  logic [LEN_W-1:0] len, fill, fill_inc, fill_d;
  logic             ovl;
  logic             cfg_ok, load_ok, shift_en, match_c;

  logic             detect_q, sat_q, err_q, busy_q;
  logic [CNT_W-1:0] count_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= UNCFG;
    else       state <= state_d;
  end

  // Next-state: a legal load restarts from FILL; a non-overlap match restarts the fill
  always_comb begin
    state_d = state;
    if (load_ok) begin
      state_d = FILL;
    end else if (shift_en) begin
      if (match_c && !ovl)        state_d = FILL;
      else if (fill_inc == len)   state_d = HUNT;
    end
  end

  // Datapath next values and the match compare against the masked low len bits
  always_comb begin
    cfg_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W));
    load_ok    = bus.cfg_load && cfg_ok;
    shift_en   = !bus.cfg_load && bus.din_valid && (state != UNCFG);
    hist_shift = {hist[PAT_W-2:0], bus.din};
    fill_inc   = (fill < len) ? fill + LEN_W'(1) : fill;
    mask       = {PAT_W{1'b1}} >> (LEN_W'(PAT_W) - len);
    match_c    = shift_en && (((hist_shift ^ pat) & mask) == '0) && (fill_inc >= len);

    hist_d = hist;
    fill_d = fill;
    if (load_ok) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      fill_d = (match_c && !ovl) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      pat  <= '0;
      len  <= '0;
      ovl  <= 1'b0;
    end else begin
      hist <= hist_d;
      fill <= fill_d;
      if (load_ok) begin
        pat <= bus.cfg_pattern;
        len <= bus.cfg_len;
        ovl <= bus.cfg_overlap;
      end
    end
  end

  // Registered status outputs; clear beats a coincident match
  always_ff @(posedge clk) begin
    if (reset) begin
      detect_q <= 1'b0;
      count_q  <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      detect_q <= match_c;
      err_q    <= bus.cfg_load && !cfg_ok;
      busy_q   <= (state_d != UNCFG);
      if (bus.clr_count) begin
        count_q <= '0;
        sat_q   <= 1'b0;
      end else if (match_c && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + CNT_W'(1);
        sat_q   <= sat_q | ((count_q + CNT_W'(1)) == {CNT_W{1'b1}});
      end
    end
  end

  assign bus.pattern_detect = detect_q;
  assign bus.match_count    = count_q;
  assign bus.count_sat      = sat_q;
  assign bus.cfg_err        = err_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_pattern_detect_fsm_param.sv
// Directed plus randomized check of pattern_detect_fsm_param against a bit-list reference model.
module tb_pattern_detect_fsm_param;
  localparam int unsigned PAT_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pattern_detect_fsm_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  pattern_detect_fsm_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: the qualified bits seen since the last restart, newest at the back
  bit        m_cfg;
  bit [7:0]  m_pat;
  int        m_len;
  bit        m_ovl;
  int        m_q[$];
  int        m_cnt;
  bit        m_sat;
  bit        e_det, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit dv, input bit d, input bit ld,
                     input logic [7:0] p, input logic [3:0] l, input bit ov, input bit clr);
    bit hit;
    reset            = r;
    bus.din_valid    = dv;
    bus.din          = d;
    bus.cfg_load     = ld;
    bus.cfg_pattern  = p;
    bus.cfg_len      = l;
    bus.cfg_overlap  = ov;
    bus.clr_count    = clr;
    @(posedge clk);
    #1;
    e_det = 1'b0;
    e_err = 1'b0;
    if (r) begin
      m_cfg = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
      m_q.delete(); m_cnt = 0; m_sat = 1'b0;
    end else begin
      if (ld) begin
        if (l >= 1 && l <= PAT_W) begin
          m_cfg = 1'b1; m_pat = p; m_len = int'(l); m_ovl = ov; m_q.delete();
        end else begin
          e_err = 1'b1;
        end
      end else if (dv && m_cfg) begin
        m_q.push_back(int'(d));
        while (m_q.size() > m_len) void'(m_q.pop_front());
        if (m_q.size() == m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (m_q[i] != int'(m_pat[m_len-1-i])) hit = 1'b0;
          if (hit) begin
            e_det = 1'b1;
            if (!m_ovl) m_q.delete();
          end
        end
      end
      if (clr) begin
        m_cnt = 0; m_sat = 1'b0;
      end else if (e_det && m_cnt < CMAX) begin
        m_cnt++;
        if (m_cnt == CMAX) m_sat = 1'b1;
      end
    end
    vectors++;
    chk("pattern_detect", 32'(bus.pattern_detect), 32'(e_det));
    chk("match_count",    32'(bus.match_count),    32'(m_cnt));
    chk("count_sat",      32'(bus.count_sat),      32'(m_sat));
    chk("cfg_err",        32'(bus.cfg_err),        32'(e_err));
    chk("busy",           32'(bus.busy),           32'(m_cfg));
  endtask

  task automatic idle();                        cyc(0, 0, 0, 0, 8'h0, 4'd0, 0, 0); endtask
  task automatic bitv(input bit d);             cyc(0, 1, d, 0, 8'h0, 4'd0, 0, 0); endtask
  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit ov);
    cyc(0, 0, 0, 1, p, l, ov, 0);
  endtask
  task automatic clear();                       cyc(0, 0, 0, 0, 8'h0, 4'd0, 0, 1); endtask
  task automatic rst();                         cyc(1, 0, 0, 0, 8'h0, 4'd0, 0, 0); endtask

  initial begin
    bit dv, d, ld, ov, clr, r;
    logic [7:0] p;
    logic [3:0] l;

    // Reset state
    rst();
    chk("reset_busy", 32'(bus.busy), 32'd0);

    // Overlap: 1,0,1,0,1 against 101 -> two pulses
    load(8'b101, 4'd3, 1'b1);
    bitv(1); bitv(0); bitv(1);
    chk("ovl_pulse1", 32'(bus.pattern_detect), 32'd1);
    bitv(0); bitv(1);
    chk("ovl_pulse2", 32'(bus.pattern_detect), 32'd1);
    idle();
    chk("ovl_width", 32'(bus.pattern_detect), 32'd0);
    chk("ovl_count", 32'(bus.match_count), 32'd2);

    // Non-overlap: same stream -> one pulse
    clear();
    load(8'b101, 4'd3, 1'b0);
    bitv(1); bitv(0); bitv(1);
    chk("novl_pulse", 32'(bus.pattern_detect), 32'd1);
    bitv(0); bitv(1);
    chk("novl_nopulse", 32'(bus.pattern_detect), 32'd0);
    chk("novl_count", 32'(bus.match_count), 32'd1);

    // Gapped input, then reload clears history
    clear();
    load(8'b1101, 4'd4, 1'b1);
    bitv(1); bitv(1); idle(); idle(); idle(); bitv(0); bitv(1);
    chk("gap_pulse", 32'(bus.pattern_detect), 32'd1);
    load(8'b1011, 4'd4, 1'b1);
    bitv(1); bitv(0); bitv(1);
    chk("reload_early", 32'(bus.pattern_detect), 32'd0);
    bitv(1);
    chk("reload_pulse", 32'(bus.pattern_detect), 32'd1);

    // Illegal lengths 0 and 9 leave configuration alone
    load(8'hFF, 4'd0, 1'b0);
    chk("err_len0", 32'(bus.cfg_err), 32'd1);
    load(8'hFF, 4'd9, 1'b0);
    chk("err_len9", 32'(bus.cfg_err), 32'd1);
    idle();
    chk("err_width", 32'(bus.cfg_err), 32'd0);
    bitv(1); bitv(0); bitv(1); bitv(1);
    chk("err_old_pat", 32'(bus.pattern_detect), 32'd1);

    // Saturation at 3 with len=1, then clear coincident with a match
    clear();
    load(8'b1, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) bitv(1);
    chk("sat_count", 32'(bus.match_count), 32'd3);
    chk("sat_flag", 32'(bus.count_sat), 32'd1);
    cyc(0, 1, 1, 0, 8'h0, 4'd0, 0, 1);
    chk("clr_win_count", 32'(bus.match_count), 32'd0);
    chk("clr_win_sat", 32'(bus.count_sat), 32'd0);

    // Reset before the last bit discards the partial match; din ignored while unconfigured
    load(8'b101, 4'd3, 1'b1);
    bitv(1); bitv(0);
    cyc(1, 1, 1, 0, 8'h0, 4'd0, 0, 0);
    bitv(1);
    chk("rst_nopulse", 32'(bus.pattern_detect), 32'd0);
    chk("rst_unbusy", 32'(bus.busy), 32'd0);
    bitv(0); bitv(1);
    chk("uncfg_ignore", 32'(bus.pattern_detect), 32'd0);

    // Load coincident with a valid bit: that bit is dropped
    cyc(0, 1, 1, 1, 8'b101, 4'd3, 1'b1, 0);
    bitv(0); bitv(1);
    chk("load_drop", 32'(bus.pattern_detect), 32'd0);
    bitv(0); bitv(1);
    chk("load_after", 32'(bus.pattern_detect), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      ld  = ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 39) == 0);
      dv  = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      ov  = 1'($urandom);
      p   = 8'($urandom);
      l   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      cyc(r, dv, d, ld, p, l, ov, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
